// File: rtl/sync_fifo_param.sv
// Single-clock circular FIFO using every slot, with an optional first-word-fall-through
// read port, an occupancy count, threshold flags and overflow/underflow pulses.
module sync_fifo_param #(
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH_W = 2,
    parameter int FWFT         = 0,
    parameter int AFULL_THR    = 3,
    parameter int AEMPTY_THR   = 1,
    parameter int ID           = 0
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_en_i,
    input  logic                    rd_en_i,
    input  logic [DATA_W-1:0]       data_i,
    output logic [DATA_W-1:0]       data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic                    almost_full_o,
    output logic                    almost_empty_o,
    output logic [FIFO_DEPTH_W:0]   count_o,
    output logic                    overflow_o,
    output logic                    underflow_o
);

    localparam int AW    = FIFO_DEPTH_W;
    localparam int DEPTH = 1 << FIFO_DEPTH_W;
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] AFULL_C  = (AW+1)'(AFULL_THR);
    localparam logic [AW:0] AEMPTY_C = (AW+1)'(AEMPTY_THR);

    if (AFULL_THR < 1 || AFULL_THR > DEPTH || AEMPTY_THR < 0 || AEMPTY_THR > DEPTH - 1) begin : g_bad_thr
        $error("sync_fifo_param[%0d]: threshold out of range (AFULL_THR=%0d AEMPTY_THR=%0d)",
               ID, AFULL_THR, AEMPTY_THR);
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              overflow_q, underflow_q;
    logic              rd_acc, wr_acc;
    logic [AW-1:0]     waddr, raddr;

    assign waddr = wr_ptr_q[AW-1:0];
    assign raddr = rd_ptr_q[AW-1:0];

    // Wrap bit distinguishes full from empty when the index bits coincide.
    assign empty_o        = (wr_ptr_q == rd_ptr_q);
    assign full_o         = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (waddr == raddr);
    assign count_o        = wr_ptr_q - rd_ptr_q;
    assign almost_full_o  = (count_o >= AFULL_C);
    assign almost_empty_o = (count_o <= AEMPTY_C);
    assign overflow_o     = overflow_q;
    assign underflow_o    = underflow_q;

    assign rd_acc = rd_en_i & ~empty_o & ~rst_i;
    assign wr_acc = wr_en_i & (~full_o | rd_acc) & ~rst_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
        if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            overflow_q  <= wr_en_i & ~wr_acc;
            underflow_q <= rd_en_i & ~rd_acc;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_acc) mem_q[waddr] <= data_i;
    end

    if (FWFT != 0) begin : g_fwft
        assign data_o = empty_o ? '0 : mem_q[raddr];
    end else begin : g_reg
        logic [DATA_W-1:0] rdata_q;

        always_ff @(posedge clk_i) begin
            if (rst_i)       rdata_q <= '0;
            else if (rd_acc) rdata_q <= mem_q[raddr];
        end

        assign data_o = rdata_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a vector table with a data scoreboard drives the registered-output
// instance, and short hand-written sequences cover the first-word-fall-through instance.
module tb_sync_fifo_param;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-output instance
    logic       rst0, wr0, rd0;
    logic [7:0] din0, dout0;
    logic       full0, empty0, afull0, aempty0, ovf0, udf0;
    logic [2:0] cnt0;

    // First-word-fall-through instance
    logic       rst1, wr1, rd1;
    logic [7:0] din1, dout1;
    logic       full1, empty1, afull1, aempty1, ovf1, udf1;
    logic [2:0] cnt1;

    sync_fifo_param #(.DATA_W(8), .FIFO_DEPTH_W(2), .FWFT(0), .AFULL_THR(3), .AEMPTY_THR(1), .ID(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst0), .wr_en_i(wr0), .rd_en_i(rd0), .data_i(din0), .data_o(dout0),
        .full_o(full0), .empty_o(empty0), .almost_full_o(afull0), .almost_empty_o(aempty0),
        .count_o(cnt0), .overflow_o(ovf0), .underflow_o(udf0)
    );

    sync_fifo_param #(.DATA_W(8), .FIFO_DEPTH_W(2), .FWFT(1), .AFULL_THR(3), .AEMPTY_THR(1), .ID(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst1), .wr_en_i(wr1), .rd_en_i(rd1), .data_i(din1), .data_o(dout1),
        .full_o(full1), .empty_o(empty1), .almost_full_o(afull1), .almost_empty_o(aempty1),
        .count_o(cnt1), .overflow_o(ovf1), .underflow_o(udf1)
    );

    typedef struct {
        logic       rst;
        logic       wr;
        logic       rd;
        logic [7:0] din;
        int         cnt;
        logic       ovf;
        logic       udf;
    } vec_t;

    vec_t       vecs[$];
    logic [7:0] sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t v(input logic rst, input logic wr, input logic rd, input logic [7:0] din,
                               input int cnt, input logic ovf, input logic udf);
        vec_t r;
        r.rst = rst; r.wr = wr; r.rd = rd; r.din = din; r.cnt = cnt; r.ovf = ovf; r.udf = udf;
        return r;
    endfunction

    task automatic step1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input int cnt, input logic [7:0] d, input logic ovf, input logic udf);
        chk({tag, " count"}, 32'(cnt1), 32'(cnt));
        chk({tag, " empty"}, 32'(empty1), 32'(cnt == 0));
        chk({tag, " full"}, 32'(full1), 32'(cnt == DEPTH));
        chk({tag, " afull"}, 32'(afull1), 32'(cnt >= 3));
        chk({tag, " aempty"}, 32'(aempty1), 32'(cnt <= 1));
        chk({tag, " data"}, 32'(dout1), 32'(d));
        chk({tag, " ovf"}, 32'(ovf1), 32'(ovf));
        chk({tag, " udf"}, 32'(udf1), 32'(udf));
    endtask

    initial begin
        int         prev_cnt;
        logic [7:0] exp_data;
        logic       rd_acc, wr_acc;
        string      tag;

        rst0 = 1'b0; wr0 = 1'b0; rd0 = 1'b0; din0 = '0;
        rst1 = 1'b1; wr1 = 1'b0; rd1 = 1'b0; din1 = '0;

        // rst wr rd din cnt ovf udf
        vecs.push_back(v(1, 1, 0, 8'h99, 0, 0, 0));
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 1, 0, 8'hA1, 1, 0, 0));
        vecs.push_back(v(0, 1, 0, 8'hA2, 2, 0, 0));
        vecs.push_back(v(0, 1, 0, 8'hA3, 3, 0, 0));
        vecs.push_back(v(0, 1, 0, 8'hA4, 4, 0, 0));
        vecs.push_back(v(0, 1, 0, 8'hA5, 4, 1, 0));
        vecs.push_back(v(0, 0, 0, 8'h00, 4, 0, 0));
        for (int k = 0; k < 4; k++) vecs.push_back(v(0, 0, 1, 8'h00, 3 - k, 0, 0));
        for (int k = 0; k < 4; k++) vecs.push_back(v(0, 1, 0, 8'hB0 + 8'(k), k + 1, 0, 0));
        for (int k = 0; k < 6; k++) vecs.push_back(v(0, 1, 1, 8'hC0 + 8'(k), 4, 0, 0));
        for (int k = 0; k < 4; k++) vecs.push_back(v(0, 0, 1, 8'h00, 3 - k, 0, 0));
        vecs.push_back(v(0, 1, 1, 8'h55, 1, 0, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 1, 0, 0));
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 0, 1));
        for (int k = 0; k < 3; k++) vecs.push_back(v(0, 1, 0, 8'hD1 + 8'(k), k + 1, 0, 0));
        vecs.push_back(v(1, 1, 0, 8'hEE, 0, 0, 0));
        vecs.push_back(v(0, 0, 1, 8'h00, 0, 0, 1));
        vecs.push_back(v(0, 0, 0, 8'h00, 0, 0, 0));

        prev_cnt = 0;
        exp_data = '0;
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            rst0 = vecs[i].rst; wr0 = vecs[i].wr; rd0 = vecs[i].rd; din0 = vecs[i].din;
            // Scoreboard: queue accepted writes, pop the word an accepted read will return.
            if (vecs[i].rst) begin
                sb.delete();
                exp_data = '0;
            end else begin
                rd_acc = vecs[i].rd && (prev_cnt > 0);
                wr_acc = vecs[i].wr && ((prev_cnt < DEPTH) || rd_acc);
                if (rd_acc) begin
                    if (sb.size() > 0) exp_data = sb.pop_front();
                    else chk($sformatf("row%0d scoreboard underrun", i), 32'd1, 32'd0);
                end
                if (wr_acc) sb.push_back(vecs[i].din);
            end
            step1();
            tag = $sformatf("row%0d", i);
            chk({tag, " count"}, 32'(cnt0), 32'(vecs[i].cnt));
            chk({tag, " empty"}, 32'(empty0), 32'(vecs[i].cnt == 0));
            chk({tag, " full"}, 32'(full0), 32'(vecs[i].cnt == DEPTH));
            chk({tag, " afull"}, 32'(afull0), 32'(vecs[i].cnt >= 3));
            chk({tag, " aempty"}, 32'(aempty0), 32'(vecs[i].cnt <= 1));
            chk({tag, " ovf"}, 32'(ovf0), 32'(vecs[i].ovf));
            chk({tag, " udf"}, 32'(udf0), 32'(vecs[i].udf));
            chk({tag, " data"}, 32'(dout0), 32'(exp_data));
            prev_cnt = vecs[i].cnt;
        end
        @(negedge clk);
        rst0 = 1'b0; wr0 = 1'b0; rd0 = 1'b0;

        // First-word-fall-through sequences
        @(negedge clk); rst1 = 1'b1; wr1 = 1'b1; din1 = 8'h77;
        step1(); chk1("fwft reset", 0, 8'h00, 0, 0);
        @(negedge clk); rst1 = 1'b0; wr1 = 1'b0;
        step1(); chk1("fwft idle", 0, 8'h00, 0, 0);
        @(negedge clk); wr1 = 1'b1; din1 = 8'h3C;
        step1(); chk1("fwft show head", 1, 8'h3C, 0, 0);
        @(negedge clk); wr1 = 1'b0;
        step1(); chk1("fwft hold head", 1, 8'h3C, 0, 0);
        @(negedge clk); rd1 = 1'b1;
        step1(); chk1("fwft pop", 0, 8'h00, 0, 0);
        step1(); chk1("fwft rd empty", 0, 8'h00, 0, 1);
        @(negedge clk); rd1 = 1'b0;
        step1(); chk1("fwft udf clear", 0, 8'h00, 0, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); wr1 = 1'b1; din1 = 8'hE1 + 8'(k);
            step1(); chk1($sformatf("fwft fill%0d", k), k + 1, 8'hE1, 0, 0);
        end
        @(negedge clk); rst1 = 1'b1; wr1 = 1'b1; din1 = 8'hEF;
        step1(); chk1("fwft mid reset", 0, 8'h00, 0, 0);
        @(negedge clk); rst1 = 1'b0; wr1 = 1'b0; rd1 = 1'b1;
        step1(); chk1("fwft post-reset rd", 0, 8'h00, 0, 1);
        @(negedge clk); rd1 = 1'b0;
        step1(); chk1("fwft final idle", 0, 8'h00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
